// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// IDLE grants round-robin and latches the operands. EXEC drives the shared ALU
// for exactly one cycle. RESP then holds the captured result on the issuing
// port until that port accepts it.
//
// Optional feature macro: ALU_ARB_OPCHECK_EN. When it is defined, requests
// with an unknown control code are accepted but bypass the ALU and answer
// with res = 0, zero = 0, res_err = 1.
//
// Handshake rule (request and response channels alike): a transfer happens on
// a rising clk edge where valid and ready are both high. A requester may drop
// valid before that edge with no effect. Request ready is high only in IDLE,
// only out of reset, and only for the granted port.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [CTRL_W-1:0] r0_ctrl,
  output logic              r0_res_valid,
  input  logic              r0_res_ready,
  output logic [DATA_W-1:0] r0_res,
  output logic              r0_res_zero,
  output logic              r0_res_err,
  // port 1
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [CTRL_W-1:0] r1_ctrl,
  output logic              r1_res_valid,
  input  logic              r1_res_ready,
  output logic [DATA_W-1:0] r1_res,
  output logic              r1_res_zero,
  output logic              r1_res_err,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zero,
  // status
  output logic              busy,
  output logic              grant_id,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Control code presented to the ALU whenever it is not executing (add).
  localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(4'b0010);

  state_t              r_state;
  state_t              w_next_state;

  // r_id is the owner shown on grant_id (resets to 0). r_last_grant feeds the
  // round-robin and resets to 1, so port 0 wins the first tie. After the
  // first transaction the two always hold the same value.
  logic                r_id;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_res0;
  logic [DATA_W-1:0]   r_res1;
  logic                r_zero0;
  logic                r_zero1;

  logic                w_any_req;
  logic                w_gnt_id;
  logic                w_accept;
  logic                w_skip;
  logic                w_resp_done;
  logic [DATA_W-1:0]   w_req_a;
  logic [DATA_W-1:0]   w_req_b;
  logic [CTRL_W-1:0]   w_req_ctrl;

  // A single requester always wins. On a tie, the port that did not win last time wins.
  assign w_any_req   = r0_valid | r1_valid;
  assign w_gnt_id    = (r0_valid & r1_valid) ? ~r_last_grant : r1_valid;
  assign w_accept    = (r_state == S_IDLE) & w_any_req;
  assign w_req_a     = w_gnt_id ? r1_a    : r0_a;
  assign w_req_b     = w_gnt_id ? r1_b    : r0_b;
  assign w_req_ctrl  = w_gnt_id ? r1_ctrl : r0_ctrl;
  assign w_resp_done = (r_state == S_RESP) & (r_id ? r1_res_ready : r0_res_ready);

`ifdef ALU_ARB_OPCHECK_EN
  function automatic logic f_legal(input logic [CTRL_W-1:0] c);
    case (c)
      CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010), CTRL_W'(4'b0110),
      CTRL_W'(4'b0111), CTRL_W'(4'b1100), CTRL_W'(4'b0011), CTRL_W'(4'b0100),
      CTRL_W'(4'b0101), CTRL_W'(4'b1000), CTRL_W'(4'b1001), CTRL_W'(4'b1010):
        f_legal = 1'b1;
      default:
        f_legal = 1'b0;
    endcase
  endfunction

  assign w_skip = ~f_legal(w_req_ctrl);
`else
  assign w_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> EXEC (or RESP for a bypassed opcode) -> RESP -> IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = w_skip ? S_RESP : S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (w_resp_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: request readies, response valids and the ALU drive
  always_comb begin
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    r0_res_valid = 1'b0;
    r1_res_valid = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_ctrl     = CTRL_IDLE;
    case (r_state)
      S_IDLE: begin
        r0_ready = rst_n & r0_valid & ~w_gnt_id;
        r1_ready = rst_n & r1_valid &  w_gnt_id;
      end
      S_EXEC: begin
        alu_a    = r_a;
        alu_b    = r_b;
        alu_ctrl = r_ctrl;
      end
      S_RESP: begin
        r0_res_valid = ~r_id;
        r1_res_valid =  r_id;
      end
      default: ;
    endcase
  end

  // Capture the request on acceptance and the ALU result at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_res0       <= '0;
      r_res1       <= '0;
      r_zero0      <= 1'b0;
      r_zero1      <= 1'b0;
    end else if (w_accept) begin
      r_a          <= w_req_a;
      r_b          <= w_req_b;
      r_ctrl       <= w_req_ctrl;
      r_id         <= w_gnt_id;
      r_last_grant <= w_gnt_id;
      if (w_skip) begin
        if (w_gnt_id) begin
          r_res1  <= '0;
          r_zero1 <= 1'b0;
        end else begin
          r_res0  <= '0;
          r_zero0 <= 1'b0;
        end
      end
    end else if (r_state == S_EXEC) begin
      if (r_id) begin
        r_res1  <= alu_c;
        r_zero1 <= alu_zero;
      end else begin
        r_res0  <= alu_c;
        r_zero0 <= alu_zero;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic r_err0;
  logic r_err1;

  // Error flag: set by a bypassed opcode, cleared by a real ALU capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (w_accept) begin
      if (w_skip) begin
        if (w_gnt_id) r_err1 <= 1'b1;
        else          r_err0 <= 1'b1;
      end
    end else if (r_state == S_EXEC) begin
      if (r_id) r_err1 <= 1'b0;
      else      r_err0 <= 1'b0;
    end
  end

  assign r0_res_err = r_err0;
  assign r1_res_err = r_err1;
`else
  assign r0_res_err = 1'b0;
  assign r1_res_err = 1'b0;
`endif

  assign r0_res      = r_res0;
  assign r1_res      = r_res1;
  assign r0_res_zero = r_zero0;
  assign r1_res_zero = r_zero1;
  assign busy        = (r_state != S_IDLE);
  assign grant_id    = r_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
// The bench also acts as the shared ALU.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          r0_valid = 0, r0_ready, r0_res_valid, r0_res_ready = 0, r0_res_zero, r0_res_err;
  logic          r1_valid = 0, r1_ready, r1_res_valid, r1_res_ready = 0, r1_res_zero, r1_res_err;
  logic [DW-1:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0, r0_res, r1_res;
  logic [CW-1:0] r0_ctrl = 0, r1_ctrl = 0;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero, busy, grant_id;
  logic [1:0]    dbg_state;

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
    .r0_res_valid(r0_res_valid), .r0_res_ready(r0_res_ready), .r0_res(r0_res),
    .r0_res_zero(r0_res_zero), .r0_res_err(r0_res_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
    .r1_res_valid(r1_res_valid), .r1_res_ready(r1_res_ready), .r1_res(r1_res),
    .r1_res_zero(r1_res_zero), .r1_res_err(r1_res_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_c(alu_c), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id), .o_dbg_state(dbg_state)
  );

  // ---------------- stand-in ALU ----------------
  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return a - b;
      4'd7:    return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd8:    return {{(DW-1){1'b0}}, (a == b)};
      4'd9:    return {{(DW-1){1'b0}}, (a != b)};
      4'd10:   return $unsigned($signed(a) >>> b[4:0]);
      4'd12:   return ~(a | b);
      default: return a + b + DW'(c);
    endcase
  endfunction

  function automatic logic ref_zero(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [CW-1:0] c);
    if (c == 4'd8 || c == 4'd9) return (a == b);
    return (ref_alu(a, b, c) == '0);
  endfunction

  assign alu_c    = ref_alu(alu_a, alu_b, alu_ctrl);
  assign alu_zero = ref_zero(alu_a, alu_b, alu_ctrl);

  function automatic logic bypassed(input logic [CW-1:0] c);
`ifdef ALU_ARB_OPCHECK_EN
    return !(c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10});
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One transaction at a time: accepted at cycle m_accept, result visible
  // from m_resp_at until the owner accepts it.
  logic          m_inflight, m_owner, m_last, m_gid, m_skip, mg;
  int            m_cyc, m_accept, m_resp_at;
  logic [DW-1:0] m_a, m_b, m_pres;
  logic [CW-1:0] m_ctrl;
  logic          m_pzero, m_perr;
  logic [DW-1:0] m_vres [2];
  logic          m_vzero[2];
  logic          m_verr [2];

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_inflight = 0; m_owner = 0; m_last = 1; m_gid = 0; m_skip = 0;
        m_cyc = 0; m_accept = 0; m_resp_at = 0;
        m_a = 0; m_b = 0; m_ctrl = 0; m_pres = 0; m_pzero = 0; m_perr = 0;
        for (int p = 0; p < 2; p++) begin
          m_vres[p] = 0; m_vzero[p] = 0; m_verr[p] = 0;
        end
      end else begin
        if (m_inflight) begin
          if (m_cyc >= m_resp_at && (m_owner ? r1_res_ready : r0_res_ready)) m_inflight = 0;
        end else if (r0_valid || r1_valid) begin
          mg = (r0_valid && r1_valid) ? !m_last : r1_valid;
          m_inflight = 1; m_owner = mg; m_last = mg; m_gid = mg; m_accept = m_cyc;
          m_a    = mg ? r1_a : r0_a;
          m_b    = mg ? r1_b : r0_b;
          m_ctrl = mg ? r1_ctrl : r0_ctrl;
          m_skip = bypassed(m_ctrl);
          if (m_skip) begin
            m_pres = 0; m_pzero = 0; m_perr = 1; m_resp_at = m_cyc + 1;
          end else begin
            m_pres = ref_alu(m_a, m_b, m_ctrl); m_pzero = ref_zero(m_a, m_b, m_ctrl);
            m_perr = 0; m_resp_at = m_cyc + 2;
          end
        end
        m_cyc++;
        if (m_inflight && m_cyc == m_resp_at) begin
          m_vres[m_owner] = m_pres; m_vzero[m_owner] = m_pzero; m_verr[m_owner] = m_perr;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic e_gnt, e_free, e_rv, e_exec;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_gnt  = (r0_valid && r1_valid) ? !m_last : r1_valid;
      e_free = rst_n && !m_inflight;
      e_rv   = m_inflight && (m_cyc >= m_resp_at);
      e_exec = m_inflight && (m_cyc == m_accept + 1) && !m_skip;
      chk_b("r0_ready", r0_ready, e_free && r0_valid && !e_gnt);
      chk_b("r1_ready", r1_ready, e_free && r1_valid && e_gnt);
      chk_b("r0_res_valid", r0_res_valid, e_rv && !m_owner);
      chk_b("r1_res_valid", r1_res_valid, e_rv && m_owner);
      chk_w("r0_res", r0_res, m_vres[0]);
      chk_w("r1_res", r1_res, m_vres[1]);
      chk_b("r0_res_zero", r0_res_zero, m_vzero[0]);
      chk_b("r1_res_zero", r1_res_zero, m_vzero[1]);
      chk_b("r0_res_err", r0_res_err, m_verr[0]);
      chk_b("r1_res_err", r1_res_err, m_verr[1]);
      chk_w("alu_a", alu_a, e_exec ? m_a : 32'd0);
      chk_w("alu_b", alu_b, e_exec ? m_b : 32'd0);
      chk_w("alu_ctrl", 32'(alu_ctrl), e_exec ? 32'(m_ctrl) : 32'd2);
      chk_b("busy", busy, m_inflight);
      chk_b("grant_id", grant_id, m_gid);
    end
  end

  // ---------------- grant / response monitors ----------------
  logic [0:0]    exp_q[$];
  logic [0:0]    gnt_log[$];
  logic [0:0]    resp_port_q[$];
  logic [DW-1:0] resp_val_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (r0_valid && r0_ready) gnt_log.push_back(1'b0);
      if (r1_valid && r1_ready) gnt_log.push_back(1'b1);
      if (r0_res_valid && r0_res_ready) begin resp_port_q.push_back(1'b0); resp_val_q.push_back(r0_res); end
      if (r1_res_valid && r1_res_ready) begin resp_port_q.push_back(1'b1); resp_val_q.push_back(r1_res); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    logic seen;
    seen = 0;
    r0_valid = 1; r0_a = a; r0_b = b; r0_ctrl = c;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (r0_ready) begin seen = 1; break; end
    end
    chk_b("r0_handshake", seen, 1'b1);
    @(posedge clk); #1;
    r0_valid = 0;
  endtask

  task automatic send1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    logic seen;
    seen = 0;
    r1_valid = 1; r1_a = a; r1_b = b; r1_ctrl = c;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (r1_ready) begin seen = 1; break; end
    end
    chk_b("r1_handshake", seen, 1'b1);
    @(posedge clk); #1;
    r1_valid = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk_b("wait_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic saw;
  initial begin
    #2 rst_n = 0;
    cmp_en = 1;

    // T1: reset state, then a single add 5+7 with timing checks
    @(posedge clk); #1;
    r0_valid = 1; r0_a = 5; r0_b = 7; r0_ctrl = 4'b0010; r0_res_ready = 1; r1_res_ready = 1;
    @(negedge clk);
    chk_b("t1_reset_ready", r0_ready, 1'b0);
    chk_b("t1_reset_busy", busy, 1'b0);
    chk_b("t1_reset_grant", grant_id, 1'b0);
    chk_w("t1_reset_res", r0_res, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk_b("t1_ready_N", r0_ready, 1'b1);
    @(posedge clk); #1 r0_valid = 0;
    @(negedge clk);
    chk_w("t1_alu_ctrl_N1", 32'(alu_ctrl), 32'd2);
    chk_w("t1_alu_a_N1", alu_a, 32'd5);
    chk_b("t1_res_valid_N1", r0_res_valid, 1'b0);
    @(negedge clk);
    chk_b("t1_res_valid_N2", r0_res_valid, 1'b1);
    chk_w("t1_res", r0_res, 32'd12);
    chk_b("t1_zero", r0_res_zero, 1'b0);
    @(negedge clk);
    chk_b("t1_busy_N3", busy, 1'b0);

    // T2: tie right after reset -> port 0 first (sub 9-9), then port 1 (0xF0|0x0F)
    do_reset(2);
    resp_port_q.delete(); resp_val_q.delete();
    fork
      send0(32'd9, 32'd9, 4'b0110);
      send1(32'hF0, 32'h0F, 4'b0001);
    join
    wait_idle();
    chk_w("t2_resp_count", resp_port_q.size(), 32'd2);
    if (resp_port_q.size() == 2) begin
      chk_b("t2_first_port", resp_port_q[0], 1'b0);
      chk_w("t2_first_res", resp_val_q[0], 32'd0);
      chk_b("t2_second_port", resp_port_q[1], 1'b1);
      chk_w("t2_second_res", resp_val_q[1], 32'hFF);
    end

    // T3: both ports continuously valid -> strict alternation 0,1,0,1,0,1
    gnt_log.delete();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fork
      repeat (3) send0($urandom, $urandom, 4'b0010);
      repeat (3) send1($urandom, $urandom, 4'b0110);
    join
    wait_idle();
    chk_w("t3_grant_count", gnt_log.size(), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
      chk_b("t3_grant_order", gnt_log[i], exp_q[i]);

    // T4: r1 beq 3,3 held in RESP by res_ready low; r0 must wait
    r1_res_ready = 0; r0_res_ready = 1;
    fork
      send1(32'd3, 32'd3, 4'b1000);
      begin
        @(posedge clk); #1;
        send0(32'd1, 32'd2, 4'b0010);
      end
      begin
        saw = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (r1_res_valid) begin saw = 1; break; end
        end
        chk_b("t4_resp_seen", saw, 1'b1);
        for (int k = 0; k < 4; k++) begin
          if (k != 0) @(negedge clk);
          chk_b("t4_hold_valid", r1_res_valid, 1'b1);
          chk_w("t4_hold_res", r1_res, 32'd1);
          chk_b("t4_hold_zero", r1_res_zero, 1'b1);
          chk_b("t4_r0_blocked", r0_ready, 1'b0);
        end
        @(posedge clk); #1 r1_res_ready = 1;
      end
    join
    wait_idle();

    // T5: reset during EXEC of r0 sll 4,1 drops the transaction
    send0(32'd4, 32'd1, 4'b0100);
    rst_n = 0;
    @(negedge clk);
    chk_b("t5_busy", busy, 1'b0);
    chk_b("t5_res_valid", r0_res_valid, 1'b0);
    chk_w("t5_alu_a", alu_a, 32'd0);
    chk_w("t5_res", r0_res, 32'd0);
    @(posedge clk); #1 rst_n = 1;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | r0_res_valid;
    end
    chk_b("t5_no_response", saw, 1'b0);
    @(posedge clk); #1;
    r0_valid = 1; r1_valid = 1; r0_ctrl = 4'b0010; r1_ctrl = 4'b0010;
    @(negedge clk);
    chk_b("t5_tie_r0", r0_ready, 1'b1);
    chk_b("t5_tie_r1", r1_ready, 1'b0);
    @(posedge clk); #1;
    r0_valid = 0; r1_valid = 0;
    wait_idle();

    // T6: control code 1111
    send0(32'd6, 32'd9, 4'b1111);
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    chk_b("t6_res_valid_N1", r0_res_valid, 1'b1);
    chk_w("t6_res", r0_res, 32'd0);
    chk_b("t6_err", r0_res_err, 1'b1);
    chk_w("t6_alu_ctrl", 32'(alu_ctrl), 32'd2);
`else
    chk_w("t6_alu_ctrl", 32'(alu_ctrl), 32'hF);
    chk_b("t6_res_valid_N1", r0_res_valid, 1'b0);
    @(negedge clk);
    chk_b("t6_res_valid_N2", r0_res_valid, 1'b1);
    chk_w("t6_res", r0_res, 32'd30);
    chk_b("t6_err", r0_res_err, 1'b0);
`endif
    wait_idle();

    // Random traffic, including occasional reset pulses
    repeat (600) begin
      @(posedge clk); #1;
      rst_n        = ($urandom_range(0, 149) != 0);
      r0_valid     = ($urandom_range(0, 2) != 0);
      r1_valid     = ($urandom_range(0, 2) != 0);
      r0_a         = $urandom;
      r1_a         = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7));
      r0_b         = ($urandom_range(0, 3) == 0) ? r0_a : $urandom;
      r1_b         = ($urandom_range(0, 3) == 0) ? r1_a : 32'($urandom_range(0, 40));
      r0_ctrl      = 4'($urandom_range(0, 15));
      r1_ctrl      = 4'($urandom_range(0, 15));
      r0_res_ready = ($urandom_range(0, 3) != 0);
      r1_res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1; r0_valid = 0; r1_valid = 0; r0_res_ready = 1; r1_res_ready = 1;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
